// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_pkg
// Purpose : Shared types and decode constants for the EX/MEM control stages
//           of the 16-bit Thumb-subset pipeline.
//           - ex_state_e : EX-stage sequencer states
//           - ex_op_e    : EX-stage operation classes
//           - c_MATCH_*  : 9-bit casez patterns on ir[15:7] (shared with ctrl_mem)
//           - is_mem_op  : true for operations that need a data-memory access
// Rev     : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } ex_state_e;

    typedef enum logic [2:0] {
        OP_ADDI  = 3'd0,
        OP_SUBSP = 3'd1,
        OP_MOVI  = 3'd2,
        OP_MOVR  = 3'd3,
        OP_LDR   = 3'd4,
        OP_STR   = 3'd5,
        OP_NONE  = 3'd6
    } ex_op_e;

    // Patterns are matched against ir[15:7]; '?' positions are don't-care.
    localparam logic [8:0] c_MATCH_ADDI3 = 9'b0001110??;
    localparam logic [8:0] c_MATCH_SUBSP = 9'b101100001;
    localparam logic [8:0] c_MATCH_MOVI  = 9'b00100????;
    localparam logic [8:0] c_MATCH_MOVR  = 9'b01000110?;
    localparam logic [8:0] c_MATCH_LDR   = 9'b01101????;
    localparam logic [8:0] c_MATCH_STR   = 9'b01100????;

    function automatic logic is_mem_op(input ex_op_e op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ex_decode.sv
`default_nettype none
// ============================================================================
// Module  : ex_decode
// Purpose : Combinational decode of the EX-stage instruction into an
//           operation class plus its immediate fields.
// Ports   : i_ir    in  16  EX instruction (16'h0000 = bubble -> OP_NONE)
//           o_op    out     operation class (ex_op_e)
//           o_imm3  out 3   ir[8:6]   (ADD imm3)
//           o_imm5  out 5   ir[10:6]  (LDR/STR word offset)
//           o_imm7  out 7   ir[6:0]   (SUB SP word offset)
//           o_imm8  out 8   ir[7:0]   (MOV imm)
// Rev     : 1.0  initial release
// ============================================================================
module ex_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output ex_op_e      o_op,
    output logic [2:0]  o_imm3,
    output logic [4:0]  o_imm5,
    output logic [6:0]  o_imm7,
    output logic [7:0]  o_imm8
);

    always_comb begin
        o_op = OP_NONE;
        casez (i_ir[15:7])
            c_MATCH_ADDI3: o_op = OP_ADDI;
            c_MATCH_SUBSP: o_op = OP_SUBSP;
            c_MATCH_MOVI:  o_op = OP_MOVI;
            c_MATCH_MOVR:  o_op = OP_MOVR;
            c_MATCH_LDR:   o_op = OP_LDR;
            c_MATCH_STR:   o_op = OP_STR;
            default:       o_op = OP_NONE;
        endcase
    end

    assign o_imm3 = i_ir[8:6];
    assign o_imm5 = i_ir[10:6];
    assign o_imm7 = i_ir[6:0];
    assign o_imm8 = i_ir[7:0];

endmodule : ex_decode
`default_nettype wire

// File: rtl/ctrl_ex.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_ex
// Purpose : Execute-stage control and datapath. Computes ALU results for
//           non-memory ops, sequences LDR/STR data-memory accesses, drives the
//           MEM pipeline register and stalls upstream while an access is open.
// Params  : TIMEOUT  max ACCESS cycles without i_dmem_ready before abort (>=2)
//           DW       data/address width
// Ports   : clk, rst (async, active-high)
//           i_hold                 freeze request from fetch/decode
//           i_ir_ex, i_rn_data, i_rm_data, i_sp_data   EX instruction/operands
//           o_ir_mem, o_result_mem MEM pipeline register
//           o_stall                stall to upstream and ctrl_mem
//           o_dmem_req/we/addr/wdata, i_dmem_ready/rdata  data-memory port
//           o_bus_err              sticky access-timeout flag
// Rev     : 1.0  initial release
// ============================================================================
module ctrl_ex
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_hold,
    input  logic [15:0]   i_ir_ex,
    input  logic [DW-1:0] i_rn_data,
    input  logic [DW-1:0] i_rm_data,
    input  logic [DW-1:0] i_sp_data,
    output logic [15:0]   o_ir_mem,
    output logic [DW-1:0] o_result_mem,
    output logic          o_stall,
    output logic          o_dmem_req,
    output logic          o_dmem_we,
    output logic [DW-1:0] o_dmem_addr,
    output logic [DW-1:0] o_dmem_wdata,
    input  logic          i_dmem_ready,
    input  logic [DW-1:0] i_dmem_rdata,
    output logic          o_bus_err
);

    localparam int                 c_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    ex_state_e          r_state;
    ex_state_e          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [15:0]        r_ir_acc;
    logic [15:0]        r_ir_mem;
    logic [DW-1:0]      r_result_mem;
    logic               r_req;
    logic               r_we;
    logic [DW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic               r_bus_err;

    ex_op_e             w_op;
    logic [2:0]         w_imm3;
    logic [4:0]         w_imm5;
    logic [6:0]         w_imm7;
    logic [7:0]         w_imm8;
    logic               w_is_mem;
    logic [DW-1:0]      w_result;
    logic               w_launch;
    logic               w_done;
    logic               w_timeout;
    logic               w_advance;

    ex_decode u_decode (
        .i_ir   (i_ir_ex),
        .o_op   (w_op),
        .o_imm3 (w_imm3),
        .o_imm5 (w_imm5),
        .o_imm7 (w_imm7),
        .o_imm8 (w_imm8)
    );

    assign w_is_mem = is_mem_op(w_op);

    // Result mux for single-cycle ops; all arithmetic wraps modulo 2^DW.
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_ADDI:  w_result = i_rn_data + DW'(w_imm3);
            OP_SUBSP: w_result = i_sp_data - DW'({w_imm7, 2'b00});
            OP_MOVI:  w_result = DW'(w_imm8);
            OP_MOVR:  w_result = i_rm_data;
            default:  w_result = '0;
        endcase
    end

    // A ready during ACCESS completes even under hold. The timeout counter
    // only advances (and can only expire) while the stage is not held.
    assign w_launch  = (r_state == IDLE) && !i_hold && w_is_mem;
    assign w_advance = (r_state == IDLE) && !i_hold && !w_is_mem;
    assign w_done    = (r_state == ACCESS) && i_dmem_ready;
    assign w_timeout = (r_state == ACCESS) && !i_dmem_ready && !i_hold
                       && (r_cnt == c_CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_state_nxt = ACCESS;
            ACCESS:  if (w_done || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The launch cycle stalls so the mem op stays on i_ir_ex; on an abort the
    // stall drops in the final cycle so the pipeline moves on with a bubble.
    always_comb begin
        o_stall = 1'b0;
        case (r_state)
            IDLE:    o_stall = w_launch;
            ACCESS:  o_stall = !i_dmem_ready && !w_timeout;
            default: o_stall = 1'b0;
        endcase
    end

    // ---------------- Datapath / pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_ir_acc     <= '0;
            r_ir_mem     <= '0;
            r_result_mem <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_bus_err    <= 1'b0;
        end else if (w_launch) begin
            r_req    <= 1'b1;
            r_we     <= (w_op == OP_STR);
            r_addr   <= i_rn_data + DW'({w_imm5, 2'b00});
            r_wdata  <= i_rm_data;
            r_ir_acc <= i_ir_ex;
            r_cnt    <= '0;
        end else if (w_done) begin
            r_req        <= 1'b0;
            r_ir_mem     <= r_ir_acc;
            r_result_mem <= r_we ? '0 : i_dmem_rdata;
        end else if (w_timeout) begin
            r_req        <= 1'b0;
            r_bus_err    <= 1'b1;
            r_ir_mem     <= '0;
            r_result_mem <= '0;
        end else if ((r_state == ACCESS) && !i_hold) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_advance) begin
            r_ir_mem     <= i_ir_ex;
            r_result_mem <= w_result;
        end
    end

    assign o_ir_mem     = r_ir_mem;
    assign o_result_mem = r_result_mem;
    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = r_addr;
    assign o_dmem_wdata = r_wdata;
    assign o_bus_err    = r_bus_err;

endmodule : ctrl_ex
`default_nettype wire

// File: tb/tb_ctrl_ex.sv
`default_nettype none
// ============================================================================
// Module  : tb_ctrl_ex
// Purpose : Directed self-checking bench for ctrl_ex. Expected MEM-register
//           contents are queued when an instruction is presented and popped
//           whenever the stage hands a result to MEM.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ctrl_ex;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_hold;
    logic [15:0]   i_ir_ex;
    logic [DW-1:0] i_rn_data, i_rm_data, i_sp_data;
    logic [15:0]   o_ir_mem;
    logic [DW-1:0] o_result_mem;
    logic          o_stall;
    logic          o_dmem_req, o_dmem_we;
    logic [DW-1:0] o_dmem_addr, o_dmem_wdata;
    logic          i_dmem_ready;
    logic [DW-1:0] i_dmem_rdata;
    logic          o_bus_err;

    always #5 clk = ~clk;

    ctrl_ex #(.TIMEOUT(TO), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (i_hold),
        .i_ir_ex      (i_ir_ex),
        .i_rn_data    (i_rn_data),
        .i_rm_data    (i_rm_data),
        .i_sp_data    (i_sp_data),
        .o_ir_mem     (o_ir_mem),
        .o_result_mem (o_result_mem),
        .o_stall      (o_stall),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ready (i_dmem_ready),
        .i_dmem_rdata (i_dmem_rdata),
        .o_bus_err    (o_bus_err)
    );

    typedef struct packed {
        logic [15:0]   ir;
        logic [DW-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   stall_cnt;
    int   req_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] ir, input logic [DW-1:0] res);
        exp_t e;
        e.ir  = ir;
        e.res = res;
        sb.push_back(e);
    endtask

    // One clock: sample the handshake just before the edge, then compare the
    // MEM register against the scoreboard if a hand-off happened.
    task automatic tick();
        logic adv;
        exp_t e;
        #1;
        adv = (o_dmem_req && i_dmem_ready) || (!o_stall && !i_hold);
        if (o_stall) stall_cnt++;
        @(posedge clk);
        #1;
        if (adv) begin
            if (sb.size() > 0) e = sb.pop_front();
            else               e = '0;
            chk("ir_mem", {48'd0, o_ir_mem}, {48'd0, e.ir});
            chk("result_mem", {32'd0, o_result_mem}, {32'd0, e.res});
        end
    endtask

    // Present one instruction and run until its result reaches MEM.
    // delay < 0 means the memory never answers.
    task automatic run(input string tag, input logic [15:0] ir,
                       input logic [DW-1:0] rn, input logic [DW-1:0] rm, input logic [DW-1:0] sp,
                       input logic [15:0] exp_ir, input logic [DW-1:0] exp_res,
                       input int delay, input logic [DW-1:0] rdata,
                       input logic [DW-1:0] exp_addr, input logic exp_we,
                       input int exp_stall, input int exp_req, input logic stray);
        int acc;
        int n;
        i_ir_ex      = ir;
        i_rn_data    = rn;
        i_rm_data    = rm;
        i_sp_data    = sp;
        i_dmem_rdata = rdata;
        push(exp_ir, exp_res);
        stall_cnt = 0;
        req_cnt   = 0;
        acc       = 0;
        n         = 0;
        while (sb.size() > 0 && n < 64) begin
            if (o_dmem_req) begin
                req_cnt++;
                chk({tag, "_addr"}, {32'd0, o_dmem_addr}, {32'd0, exp_addr});
                chk({tag, "_we"}, {63'd0, o_dmem_we}, {63'd0, exp_we});
                chk({tag, "_wdata"}, {32'd0, o_dmem_wdata}, {32'd0, rm});
                i_dmem_ready = (delay >= 0) && (acc >= delay);
                acc++;
            end else begin
                i_dmem_ready = stray;
            end
            tick();
            n++;
        end
        chk({tag, "_completed"}, 64'(n < 64), 64'd1);
        i_ir_ex      = 16'h0000;
        i_dmem_ready = 1'b0;
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
        chk({tag, "_req_cycles"}, 64'(req_cnt), 64'(exp_req));
    endtask

    initial begin
        rst          = 1'b1;
        i_hold       = 1'b0;
        i_ir_ex      = '0;
        i_rn_data    = '0;
        i_rm_data    = '0;
        i_sp_data    = '0;
        i_dmem_ready = 1'b0;
        i_dmem_rdata = '0;
        #3;
        chk("rst_ir_mem", {48'd0, o_ir_mem}, 64'd0);
        chk("rst_result", {32'd0, o_result_mem}, 64'd0);
        chk("rst_req", {63'd0, o_dmem_req}, 64'd0);
        chk("rst_we", {63'd0, o_dmem_we}, 64'd0);
        chk("rst_addr", {32'd0, o_dmem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, o_dmem_wdata}, 64'd0);
        chk("rst_bus_err", {63'd0, o_bus_err}, 64'd0);
        chk("rst_stall", {63'd0, o_stall}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Single-cycle ops: no stall, no memory request.
        run("add_imm3", 16'h1C8A, 32'd5, 32'd0, 32'd0, 16'h1C8A, 32'd7,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        run("add_wrap", 16'h1C8A, 32'hFFFF_FFFF, 32'd0, 32'd0, 16'h1C8A, 32'd1,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        run("movi_stray_ready", 16'h20A5, 32'd0, 32'd0, 32'd0, 16'h20A5, 32'h0000_00A5,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b1);
        run("movr", 16'h4608, 32'd0, 32'h1234_5678, 32'd0, 16'h4608, 32'h1234_5678,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        run("subsp", 16'hB084, 32'd0, 32'd0, 32'h0000_1000, 16'hB084, 32'h0000_0FF0,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        run("subsp_wrap", 16'hB084, 32'd0, 32'd0, 32'd8, 16'hB084, 32'hFFFF_FFF8,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        run("undecoded", 16'hFFFF, 32'd9, 32'd9, 32'd9, 16'hFFFF, 32'd0,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        tick();

        // Memory ops.
        run("ldr_zero_wait", 16'h6848, 32'h100, 32'd0, 32'd0, 16'h6848, 32'hDEAD_BEEF,
            0, 32'hDEAD_BEEF, 32'h104, 1'b0, 1, 1, 1'b1);
        run("str_wait5", 16'h6048, 32'h200, 32'h55, 32'd0, 16'h6048, 32'd0,
            5, 32'hFFFF_FFFF, 32'h204, 1'b1, 6, 6, 1'b0);
        run("ldr_ready_at_limit", 16'h6848, 32'h300, 32'd0, 32'd0, 16'h6848, 32'hCAFE_0001,
            TO - 1, 32'hCAFE_0001, 32'h304, 1'b0, TO, TO, 1'b0);
        chk("no_err_ready_at_limit", {63'd0, o_bus_err}, 64'd0);

        // Hold: a held IDLE mem op must not launch; a ready under hold completes.
        i_ir_ex      = 16'h6848;
        i_rn_data    = 32'h400;
        i_dmem_rdata = 32'hA5A5_0F0F;
        i_hold       = 1'b1;
        push(16'h6848, 32'hA5A5_0F0F);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("hold_idle_stall", {63'd0, o_stall}, 64'd0);
            tick();
            chk("hold_idle_no_req", {63'd0, o_dmem_req}, 64'd0);
        end
        i_hold = 1'b0;
        tick();
        chk("hold_launch_req", {63'd0, o_dmem_req}, 64'd1);
        chk("hold_launch_addr", {32'd0, o_dmem_addr}, 64'h404);
        i_hold       = 1'b1;
        i_dmem_ready = 1'b1;
        tick();
        chk("hold_done_consumed", 64'(sb.size()), 64'd0);
        chk("hold_done_req", {63'd0, o_dmem_req}, 64'd0);
        i_ir_ex      = 16'h0000;
        i_dmem_ready = 1'b0;
        i_hold       = 1'b0;
        tick();

        // Timeout: bubble into MEM, sticky error, stall released on the last cycle.
        run("ldr_timeout", 16'h6848, 32'h500, 32'd0, 32'd0, 16'h0000, 32'd0,
            -1, 32'd0, 32'h504, 1'b0, TO, TO, 1'b0);
        chk("timeout_bus_err", {63'd0, o_bus_err}, 64'd1);
        chk("timeout_req_low", {63'd0, o_dmem_req}, 64'd0);
        run("add_after_err", 16'h1C8A, 32'd10, 32'd0, 32'd0, 16'h1C8A, 32'd12,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        chk("bus_err_sticky", {63'd0, o_bus_err}, 64'd1);

        // Async reset in the middle of an access.
        i_ir_ex   = 16'h6048;
        i_rn_data = 32'h600;
        i_rm_data = 32'h77;
        tick();
        i_ir_ex = 16'h0000;
        tick();
        chk("pre_rst_req", {63'd0, o_dmem_req}, 64'd1);
        chk("pre_rst_stall", {63'd0, o_stall}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req", {63'd0, o_dmem_req}, 64'd0);
        chk("async_rst_stall", {63'd0, o_stall}, 64'd0);
        chk("async_rst_ir", {48'd0, o_ir_mem}, 64'd0);
        chk("async_rst_result", {32'd0, o_result_mem}, 64'd0);
        chk("async_rst_bus_err", {63'd0, o_bus_err}, 64'd0);
        chk("async_rst_addr", {32'd0, o_dmem_addr}, 64'd0);
        chk("async_rst_wdata", {32'd0, o_dmem_wdata}, 64'd0);
        #2;
        rst = 1'b0;
        sb.delete();
        tick();
        chk("post_rst_idle_req", {63'd0, o_dmem_req}, 64'd0);
        run("movi_after_rst", 16'h2011, 32'd0, 32'd0, 32'd0, 16'h2011, 32'h11,
            -1, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ctrl_ex
`default_nettype wire
